// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide single-port memory between instruction fetch and data access.
// Define MEM_ALIGN_CHECK_EN to reject misaligned data accesses; mode: 00 word, 01 half, 10 byte.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [31:0]       ifData,
  output logic              ifReady,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [31:0]       dWData,
  output logic [31:0]       dRData,
  output logic              dReady,
  output logic              alignErr,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [3:0]        memBe,
  output logic [31:0]       memWData,
  input  logic [31:0]       memRData,
  input  logic              memAck,
  output logic              stall
);
  localparam logic [1:0] MEM_HALF = 2'd1, MEM_BYTE = 2'd2;
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic [1:0] off_q, off_d, mode_q, mode_d;
  logic err_q, err_d;
  logic if_ready_q, if_ready_d, d_ready_q, d_ready_d, align_err_q, align_err_d;
  logic [31:0] if_data_q, if_data_d, d_rdata_q, d_rdata_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic d_elig, if_elig, grant_d, grant_if, is_half, is_byte, mis;
  logic [1:0] off;
  logic [3:0] be;
  logic [31:0] ld, ld_ext;
  assign stall = (ifReq & ~ifReady) | ((memRead | memWrite) & ~dReady);
  assign d_elig = (memRead | memWrite) & ~d_ready_q;
  assign if_elig = ifReq & ~if_ready_q;
  assign grant_d = d_elig & (~if_elig | ~last_d_q);
  assign grant_if = if_elig & ~grant_d;
  assign is_half = mode == MEM_HALF;
  assign is_byte = mode == MEM_BYTE;
  assign off = is_byte ? dAddr[1:0] : is_half ? {dAddr[1], 1'b0} : 2'b00;
  assign be = is_byte ? 4'b0001 << off : is_half ? (dAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = is_half ? dAddr[0] : ~is_byte & (|dAddr[1:0]);
`else
  assign mis = 1'b0;
`endif
  // Loads come back in the lanes chosen at issue time, so shift by the stored offset.
  assign ld = memRData >> {off_q, 3'b000};
  assign ld_ext = mode_q == MEM_BYTE ? {24'd0, ld[7:0]} : mode_q == MEM_HALF ? {16'd0, ld[15:0]} : ld;
  always_comb begin
    state_d = state_q;
    last_d_d = last_d_q;
    off_d = off_q;
    mode_d = mode_q;
    err_d = err_q;
    if_ready_d = 1'b0;
    d_ready_d = 1'b0;
    align_err_d = 1'b0;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = D_BUSY;
          last_d_d = 1'b1;
          off_d = off;
          mode_d = mode;
          err_d = mis;
          mem_req_d = ~mis;
          mem_we_d = memWrite & ~mis;
          mem_addr_d = dAddr & ~ADDR_W'(3);
          mem_be_d = be;
          mem_wdata_d = dWData << {off, 3'b000};
        end else if (grant_if) begin
          state_d = IF_BUSY;
          last_d_d = 1'b0;
          mem_req_d = 1'b1;
          mem_we_d = 1'b0;
          mem_addr_d = ifAddr & ~ADDR_W'(3);
          mem_be_d = 4'b1111;
        end
      end
      IF_BUSY: begin
        if (memAck) begin
          state_d = IDLE;
          mem_req_d = 1'b0;
          mem_we_d = 1'b0;
          if_data_d = memRData;
          if_ready_d = 1'b1;
        end
      end
      default: begin
        if (err_q) begin
          state_d = IDLE;
          err_d = 1'b0;
          d_ready_d = 1'b1;
          align_err_d = 1'b1;
          d_rdata_d = 32'd0;
        end else if (memAck) begin
          state_d = IDLE;
          mem_req_d = 1'b0;
          mem_we_d = 1'b0;
          d_rdata_d = ld_ext;
          d_ready_d = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_d_q <= 1'b0;
      off_q <= 2'd0;
      mode_q <= 2'd0;
      err_q <= 1'b0;
      if_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      align_err_q <= 1'b0;
      if_data_q <= 32'd0;
      d_rdata_q <= 32'd0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q <= 4'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      off_q <= off_d;
      mode_q <= mode_d;
      err_q <= err_d;
      if_ready_q <= if_ready_d;
      d_ready_q <= d_ready_d;
      align_err_q <= align_err_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign ifData = if_data_q;
  assign ifReady = if_ready_q;
  assign dRData = d_rdata_q;
  assign dReady = d_ready_q;
  assign alignErr = align_err_q;
  assign memReq = mem_req_q;
  assign memWe = mem_we_q;
  assign memAddr = mem_addr_q;
  assign memBe = mem_be_q;
  assign memWData = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory responder.
module tb_mem_arbiter;
  logic clk = 0, reset = 1;
  logic ifReq = 0, memRead = 0, memWrite = 0;
  logic [31:0] ifAddr = 0, dAddr = 0, dWData = 0, memRData = 0;
  logic [1:0] mode = 0;
  logic [31:0] ifData, dRData, memAddr, memWData;
  logic ifReady, dReady, alignErr, memReq, memWe, stall, memAck;
  logic [3:0] memBe;
  logic ack_r = 0, late_ack = 0, resp_en = 1;
  int lat = 1, checks = 0, errors = 0, dcnt = 0, icnt = 0;
  logic [31:0] mem [0:63];
  typedef struct {logic [31:0] d; logic e; logic c;} dexp_t;
  typedef struct {logic we; logic [31:0] a; logic [3:0] be; logic [31:0] wd;} rexp_t;
  dexp_t dq[$];
  logic [31:0] iq[$];
  rexp_t rq[$];
  assign memAck = ack_r | late_ack;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifReady(ifReady),
    .memRead(memRead), .memWrite(memWrite), .mode(mode), .dAddr(dAddr), .dWData(dWData),
    .dRData(dRData), .dReady(dReady), .alignErr(alignErr), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memBe(memBe), .memWData(memWData), .memRData(memRData), .memAck(memAck),
    .stall(stall)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Memory responder: checks each request against the expected queue, acks after lat cycles.
  initial begin
    rexp_t r;
    forever begin
      @(negedge clk);
      if (resp_en && memReq) begin
        if (rq.size() == 0) chk("unexpected_memReq", memAddr, 32'hFFFFFFFF);
        else begin
          r = rq.pop_front();
          chk("memWe", {31'd0, memWe}, {31'd0, r.we});
          chk("memAddr", memAddr, r.a);
          chk("memBe", {28'd0, memBe}, {28'd0, r.be});
          if (r.we) chk("memWData", memWData, r.wd);
        end
        repeat (lat) @(posedge clk);
        #1;
        ack_r = 1;
        memRData = mem[memAddr[7:2]];
        if (memWe)
          for (int b = 0; b < 4; b++)
            if (memBe[b]) mem[memAddr[7:2]][8*b +: 8] = memWData[8*b +: 8];
        @(posedge clk);
        #1 ack_r = 0;
      end
    end
  end
  // Ready monitor
  initial begin
    dexp_t e;
    forever begin
      @(negedge clk);
      if (dReady) begin
        dcnt++;
        if (dq.size() == 0) chk("unexpected_dReady", dRData, 32'hFFFFFFFF);
        else begin
          e = dq.pop_front();
          if (e.c) chk("dRData", dRData, e.d);
          chk("alignErr", {31'd0, alignErr}, {31'd0, e.e});
        end
      end
      if (ifReady) begin
        icnt++;
        if (iq.size() == 0) chk("unexpected_ifReady", ifData, 32'hFFFFFFFF);
        else chk("ifData", ifData, iq.pop_front());
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  task automatic d_txn(input logic rd, input logic wr, input logic [1:0] md, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_cyc);
    int n;
    @(posedge clk);
    #1;
    memRead = rd;
    memWrite = wr;
    mode = md;
    dAddr = a;
    dWData = wd;
    n = 0;
    @(negedge clk);
    chk("d_stall_c0", {31'd0, stall}, 32'd1);
    while (!dReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d_latency", n, exp_cyc);
    chk("d_stall_rdy", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    memRead = 0;
    memWrite = 0;
  endtask
  task automatic if_txn(input logic [31:0] a, input int exp_cyc);
    int n;
    @(posedge clk);
    #1;
    ifReq = 1;
    ifAddr = a;
    n = 0;
    @(negedge clk);
    chk("if_stall_c0", {31'd0, stall}, 32'd1);
    while (!ifReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("if_latency", n, exp_cyc);
    chk("if_stall_rdy", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 ifReq = 0;
  endtask
  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h1234ABCD;
    mem[16] = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    chk("rst_memReq", {31'd0, memReq}, 32'd0);
    chk("rst_ready", {30'd0, dReady, ifReady}, 32'd0);
    chk("rst_memBe", {28'd0, memBe}, 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 0;
    rq.push_back('{1'b0, 32'h10, 4'b1111, 32'd0});
    dq.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
    d_txn(1, 0, 2'd0, 32'h10, 32'd0, 3);
    rq.push_back('{1'b1, 32'h10, 4'b1000, 32'hAB000000});
    dq.push_back('{32'd0, 1'b0, 1'b0});
    d_txn(0, 1, 2'd2, 32'h13, 32'h000000AB, 3);
    rq.push_back('{1'b0, 32'h10, 4'b1111, 32'd0});
    dq.push_back('{32'hABADBEEF, 1'b0, 1'b1});
    d_txn(1, 0, 2'd0, 32'h10, 32'd0, 3);
    rq.push_back('{1'b0, 32'h20, 4'b1100, 32'd0});
    dq.push_back('{32'h00001234, 1'b0, 1'b1});
    d_txn(1, 0, 2'd1, 32'h22, 32'd0, 3);
    rq.push_back('{1'b0, 32'h20, 4'b0010, 32'd0});
    dq.push_back('{32'h000000AB, 1'b0, 1'b1});
    d_txn(1, 0, 2'd2, 32'h21, 32'd0, 3);
    rq.push_back('{1'b1, 32'h30, 4'b0011, 32'h0000BEEF});
    dq.push_back('{32'd0, 1'b0, 1'b0});
    d_txn(1, 1, 2'd1, 32'h30, 32'h0000BEEF, 3);
    rq.push_back('{1'b1, 32'h30, 4'b1100, 32'h55550000});
    dq.push_back('{32'd0, 1'b0, 1'b0});
    d_txn(0, 1, 2'd1, 32'h32, 32'hFFFF5555, 3);
    lat = 2;
    rq.push_back('{1'b0, 32'h30, 4'b1111, 32'd0});
    dq.push_back('{32'h5555BEEF, 1'b0, 1'b1});
    d_txn(1, 0, 2'd0, 32'h30, 32'd0, 4);
    lat = 1;
    rq.push_back('{1'b0, 32'h40, 4'b1111, 32'd0});
    iq.push_back(32'hCAFEF00D);
    if_txn(32'h43, 3);
    // Contention: both held; grants must alternate D, IF, D, IF.
    rq.push_back('{1'b0, 32'h10, 4'b1111, 32'd0});
    rq.push_back('{1'b0, 32'h40, 4'b1111, 32'd0});
    rq.push_back('{1'b0, 32'h10, 4'b1111, 32'd0});
    rq.push_back('{1'b0, 32'h40, 4'b1111, 32'd0});
    dq.push_back('{32'hABADBEEF, 1'b0, 1'b1});
    dq.push_back('{32'hABADBEEF, 1'b0, 1'b1});
    iq.push_back(32'hCAFEF00D);
    iq.push_back(32'hCAFEF00D);
    @(posedge clk);
    #1;
    dcnt = 0;
    icnt = 0;
    ifReq = 1;
    ifAddr = 32'h40;
    memRead = 1;
    mode = 2'd0;
    dAddr = 32'h10;
    n = 0;
    @(negedge clk);
    while (dcnt + icnt < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ifReq = 0;
    memRead = 0;
    chk("contend_cycles", n, 12);
    chk("contend_d", dcnt, 2);
    chk("contend_if", icnt, 2);
`ifdef MEM_ALIGN_CHECK_EN
    dq.push_back('{32'd0, 1'b1, 1'b1});
    d_txn(0, 1, 2'd0, 32'h02, 32'h11223344, 2);
    dq.push_back('{32'd0, 1'b1, 1'b1});
    d_txn(1, 0, 2'd1, 32'h23, 32'd0, 2);
`else
    rq.push_back('{1'b0, 32'h10, 4'b1111, 32'd0});
    dq.push_back('{32'hABADBEEF, 1'b0, 1'b1});
    d_txn(1, 0, 2'd0, 32'h12, 32'd0, 3);
    rq.push_back('{1'b0, 32'h20, 4'b1100, 32'd0});
    dq.push_back('{32'h00001234, 1'b0, 1'b1});
    d_txn(1, 0, 2'd1, 32'h23, 32'd0, 3);
`endif
    // Reset mid-transaction; the late ack must be ignored.
    resp_en = 0;
    @(posedge clk);
    #1;
    memRead = 1;
    mode = 2'd0;
    dAddr = 32'h10;
    repeat (2) @(negedge clk);
    chk("mid_memReq", {31'd0, memReq}, 32'd1);
    reset = 1;
    #1;
    chk("rst_async_memReq", {31'd0, memReq}, 32'd0);
    memRead = 0;
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1 late_ack = 1;
    @(posedge clk);
    #1 late_ack = 0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_dReady", {30'd0, dReady, memReq}, 32'd0);
    end
    resp_en = 1;
    rq.push_back('{1'b0, 32'h40, 4'b1111, 32'd0});
    iq.push_back(32'hCAFEF00D);
    if_txn(32'h40, 3);
    repeat (3) @(negedge clk);
    chk("dq_empty", dq.size(), 0);
    chk("iq_empty", iq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter that shares one single-port, word-wide memory between the instruction-fetch port (IF) and the data-access port (MEM stage). Data requests arrive already decoded into `memRead`/`memWrite`/`mode` by the MEM-stage decoder. The block does the following:
- runs a request/acknowledge transaction with the memory;
- maps byte/half/word accesses onto byte enables and lane shifts;
- raises a pipeline `stall` until each requester is served.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ifReq`  in  1  fetch request, level; held until `ifReady`.
- `ifAddr`  in  ADDR_W  fetch byte address.
- `ifData`  out  32  fetched word.
- `ifReady`  out  1  one-cycle pulse; `ifData` is valid.
- `memRead`  in  1  data read request, level.
- `memWrite`  in  1  data write request, level.
- `mode`  in  2  `MEM_WORD` / `MEM_HALF` / `MEM_BYTE` (ISA.v encodings).
- `dAddr`  in  ADDR_W  data byte address.
- `dWData`  in  32  store data, right-aligned.
- `dRData`  out  32  load data, right-aligned, zero-extended.
- `dReady`  out  1  one-cycle pulse; data transaction done.
- `alignErr`  out  1  pulses with `dReady` on a misaligned access (see Configuration).
- `memReq`  out  1  memory request, held until `memAck`.
- `memWe`  out  1  write strobe qualifying `memReq`.
- `memAddr`  out  ADDR_W  word address, low 2 bits forced to 0.
- `memBe`  out  4  byte enables.
- `memWData`  out  32  lane-shifted write data.
- `memRData`  in  32  read data, valid when `memAck` is high.
- `memAck`  in  1  memory done; one or more cycles after `memReq`.
- `stall`  out  1  combinational: `(ifReq & ~ifReady) | ((memRead|memWrite) & ~dReady)`.

## Operation
States: IDLE, IF_BUSY, D_BUSY.

IDLE, arbitration at each rising edge:
- Only data pending -> D_BUSY.
- Only fetch pending -> IF_BUSY.
- Both pending -> grant the port not granted last (`lastGrant` register, reset value = IF, so data wins first).
- A requester whose ready is high this cycle is not eligible at this edge.

BUSY:
- On entry, register `memReq`=1, `memAddr`, `memWe`, `memBe`, `memWData`. These stay stable until `memAck`.
- On the `memAck` edge: drop `memReq`, capture the read data, pulse the port's ready for exactly one cycle, return to IDLE.
- `memAck` is ignored in IDLE.

Data accesses:
- If `memWrite` and `memRead` are both high, the access is a write.
- Lanes are little-endian: byte k = bits [8k+7:8k].
- `MEM_WORD`: `memBe`=1111, data unshifted.
- `MEM_HALF`: `memBe` = 0011 when `dAddr[1]`=0, else 1100; data shifted by 16·`dAddr[1]`.
- `MEM_BYTE`: `memBe` = 0001 << `dAddr[1:0]`; data shifted by 8·`dAddr[1:0]`.
- Loads: `dRData` = the selected lanes shifted down, upper bits 0. Sign extension is done downstream.

Fetch accesses: `memBe`=1111, `memWe`=0.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE, `lastGrant` = IF;
  - all outputs 0 except the combinational `stall`;
  - the pending transaction is abandoned; a late `memAck` is ignored.
- Latency with `memAck` k cycles after `memReq` rises (k≥1):
  - ready pulses at edge 1+k+1 after the request is sampled;
  - i.e. 3 cycles minimum with a single-cycle memory.
- Ready and read data are registered. `ifData`/`dRData` hold their value until the next transaction on the same port.
- Back-to-back on the same port: at least one IDLE cycle between them.
- Alternating ports: the other port is granted at the edge ending the ready cycle.
- `stall` deasserts in the same cycle as the ready pulse.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned data accesses are `MEM_WORD` with `dAddr[1:0]`≠0, or `MEM_HALF` with `dAddr[0]`=1.
  - Such an access issues no memory request. The block goes IDLE -> D_BUSY -> ready, with `dReady`=`alignErr`=1 one cycle later, `dRData`=0, and no write performed.
- Undefined:
  - `alignErr` is tied 0.
  - Low address bits beyond the access size are ignored (word uses bits [1:0]=0, half uses bit 0=0).

## Test plan
- Word load: `memRead`=1, `MEM_WORD`, `dAddr`=0x10, memory returns 0xDEADBEEF after 1 cycle -> `memAddr`=0x10, `memBe`=1111, `dReady` at cycle 3, `dRData`=0xDEADBEEF, `stall` high for cycles 0–2.
- Byte store: `memWrite`, `MEM_BYTE`, `dAddr`=0x13, `dWData`=0x000000AB -> `memBe`=1000, `memWData[31:24]`=0xAB, `memWe`=1.
- Half load: `MEM_HALF`, `dAddr`=0x22, memory returns 0x1234ABCD -> `dRData`=0x00001234.
- Contention: `ifReq` and `memRead` both asserted continuously -> grants alternate D, IF, D, IF; neither port waits more than one foreign transaction.
- Reset mid-D_BUSY with `memReq`=1 -> `memReq`=0 immediately; a later `memAck` produces no `dReady`; the next `ifReq` is served normally.
- With `MEM_ALIGN_CHECK_EN`: `MEM_WORD` store at 0x02 -> `memReq` never asserted, `dReady`=`alignErr`=1 one cycle after D_BUSY.
